// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for the 16-bit multi-cycle datapath. It fetches through MAR/MDR/IR,
// decodes op_code/dst/src1/src2, and then sequences register loads, X-bus
// drivers, register-bank accesses and the ALU function for each cycle. It also
// owns the memory read/write handshake and a latched zero flag used by BZ.
//
// Parameters
//   PC_STEP      PC increment carried by the thash2 bus constant (only 2 is
//                supported).
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-low reset
//   op_code      [4:0] opcode from the instruction decoder
//   dst/src1/src2[2:0] register fields from the instruction decoder
//   addr_mode    [1:0] unused in this revision
//   flags        [3:0] ALU flags, bit3 = Z
//   mem_ready    memory completes the current access this cycle
//   ld*          datapath load strobes (ldR, ldSP tied low)
//   t*           X-bus drivers, at most one active (tMAR, tR, thash4 tied low)
//   rchoosein    [2:0] register-bank write select
//   rchooseout   [2:0] register-bank read select
//   reg_write/reg_read register-bank strobes
//   funSel       [1:0] ALU function: 00 PASS X, 01 ADD, 10 SUB, 11 AND
//   mem_rd/mem_wr memory requests, held until mem_ready
//   halted       core is in HALT
//   illegal      one-cycle pulse in DEC on an undefined opcode
//
// Build option
//   CTRL_ILLEGAL_TRAP_EN  when defined, undefined opcodes pulse `illegal` and
//                         enter HALT; otherwise they behave as NOP and
//                         `illegal` stays 0.
//
// Outputs are decoded combinationally from the state register and are forced
// to 0 whenever rst is low, so a reset taken during a memory wait drops the
// request in the same cycle.
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int PC_STEP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] op_code,
  input  logic [2:0] dst,
  input  logic [2:0] src1,
  input  logic [2:0] src2,
  input  logic [1:0] addr_mode,
  input  logic [3:0] flags,
  input  logic       mem_ready,
  output logic       ldMDR,
  output logic       ldMDB,
  output logic       ldMAR,
  output logic       ldIR,
  output logic       ldPC,
  output logic       ldR,
  output logic       ldSP,
  output logic       ldYreg,
  output logic       tMDR,
  output logic       tMAR,
  output logic       tPC,
  output logic       tR,
  output logic       treg,
  output logic       thash4,
  output logic       thash2,
  output logic [2:0] rchoosein,
  output logic [2:0] rchooseout,
  output logic       reg_write,
  output logic       reg_read,
  output logic [1:0] funSel,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       halted,
  output logic       illegal
);

  typedef enum logic [4:0] {
    ST_F0   = 5'd0,
    ST_F1   = 5'd1,
    ST_FW   = 5'd2,
    ST_F2   = 5'd3,
    ST_DEC  = 5'd4,
    ST_E0   = 5'd5,
    ST_E1   = 5'd6,
    ST_I0   = 5'd7,
    ST_I1   = 5'd8,
    ST_IW   = 5'd9,
    ST_M0   = 5'd10,
    ST_M1   = 5'd11,
    ST_M2   = 5'd12,
    ST_S1   = 5'd13,
    ST_S2   = 5'd14,
    ST_J0   = 5'd15,
    ST_HALT = 5'd16
  } state_t;

  localparam logic [4:0] OP_NOP  = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_AND  = 5'b00011;
  localparam logic [4:0] OP_MOV  = 5'b00100;
  localparam logic [4:0] OP_LDI  = 5'b00101;
  localparam logic [4:0] OP_LD   = 5'b00110;
  localparam logic [4:0] OP_ST   = 5'b00111;
  localparam logic [4:0] OP_JMP  = 5'b01000;
  localparam logic [4:0] OP_BZ   = 5'b01001;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [1:0] FUN_PASS = 2'b00;
  localparam logic [1:0] FUN_ADD  = 2'b01;
  localparam logic [1:0] FUN_SUB  = 2'b10;
  localparam logic [1:0] FUN_AND  = 2'b11;

  state_t     state_r;
  state_t     next_s;
  logic [4:0] op_r;
  logic [2:0] dst_r;
  logic [2:0] src1_r;
  logic [2:0] src2_r;
  logic       zflag_r;

  // addr_mode, the non-Z flags and PC_STEP do not affect sequencing.
  logic unused_s;
  assign unused_s = ^{addr_mode, flags[2:0], (PC_STEP == 2)};

  // Permanently idle strobes and bus drivers.
  assign ldR    = 1'b0;
  assign ldSP   = 1'b0;
  assign tMAR   = 1'b0;
  assign tR     = 1'b0;
  assign thash4 = 1'b0;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_F0;
    end else begin
      state_r <= next_s;
    end
  end

  // Instruction fields captured in DEC so execution does not depend on the
  // decoder holding them; zero flag captured at the end of ALU-op E1 only.
  always_ff @(posedge clk) begin
    if (!rst) begin
      op_r    <= OP_NOP;
      dst_r   <= 3'd0;
      src1_r  <= 3'd0;
      src2_r  <= 3'd0;
      zflag_r <= 1'b0;
    end else begin
      if (state_r == ST_DEC) begin
        op_r   <= op_code;
        dst_r  <= dst;
        src1_r <= src1;
        src2_r <= src2;
      end else begin
        op_r   <= op_r;
        dst_r  <= dst_r;
        src1_r <= src1_r;
        src2_r <= src2_r;
      end
      if ((state_r == ST_E1) && (op_r != OP_MOV)) begin
        zflag_r <= flags[3];
      end else begin
        zflag_r <= zflag_r;
      end
    end
  end

  // Next-state and per-state output decode.
  always_comb begin
    next_s     = state_r;
    ldMDR      = 1'b0;
    ldMDB      = 1'b0;
    ldMAR      = 1'b0;
    ldIR       = 1'b0;
    ldPC       = 1'b0;
    ldYreg     = 1'b0;
    tMDR       = 1'b0;
    tPC        = 1'b0;
    treg       = 1'b0;
    thash2     = 1'b0;
    rchoosein  = 3'd0;
    rchooseout = 3'd0;
    reg_write  = 1'b0;
    reg_read   = 1'b0;
    funSel     = FUN_PASS;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    halted     = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      next_s = ST_F0;
    end else begin
      case (state_r)
        // PC -> MAR and Yreg; I0 fetches the LDI immediate the same way.
        ST_F0, ST_I0: begin
          tPC    = 1'b1;
          ldMAR  = 1'b1;
          ldYreg = 1'b1;
          next_s = (state_r == ST_F0) ? ST_F1 : ST_I1;
        end
        // PC += 2 while the read is issued; ready here skips the wait state.
        ST_F1, ST_I1: begin
          thash2 = 1'b1;
          funSel = FUN_ADD;
          ldPC   = 1'b1;
          mem_rd = 1'b1;
          ldMDR  = mem_ready;
          if (mem_ready) begin
            next_s = (state_r == ST_F1) ? ST_F2 : ST_M2;
          end else begin
            next_s = (state_r == ST_F1) ? ST_FW : ST_IW;
          end
        end
        ST_FW, ST_IW, ST_M1: begin
          mem_rd = 1'b1;
          ldMDR  = mem_ready;
          if (mem_ready) begin
            next_s = (state_r == ST_FW) ? ST_F2 : ST_M2;
          end else begin
            next_s = state_r;
          end
        end
        ST_F2: begin
          tMDR   = 1'b1;
          ldIR   = 1'b1;
          next_s = ST_DEC;
        end
        ST_DEC: begin
          case (op_code)
            OP_NOP:                         next_s = ST_F0;
            OP_ADD, OP_SUB, OP_AND, OP_MOV: next_s = ST_E0;
            OP_LDI:                         next_s = ST_I0;
            OP_LD, OP_ST:                   next_s = ST_M0;
            OP_JMP:                         next_s = ST_J0;
            OP_BZ:                          next_s = zflag_r ? ST_J0 : ST_F0;
            OP_HALT:                        next_s = ST_HALT;
            default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
              illegal = 1'b1;
              next_s  = ST_HALT;
`else
              next_s  = ST_F0;
`endif
            end
          endcase
        end
        ST_E0: begin
          reg_read   = 1'b1;
          treg       = 1'b1;
          rchooseout = src1_r;
          ldYreg     = 1'b1;
          next_s     = ST_E1;
        end
        // MOV reuses E1 as a PASS of src1 into dst.
        ST_E1: begin
          reg_read   = 1'b1;
          treg       = 1'b1;
          rchoosein  = dst_r;
          reg_write  = 1'b1;
          next_s     = ST_F0;
          case (op_r)
            OP_ADD: begin rchooseout = src2_r; funSel = FUN_ADD;  end
            OP_SUB: begin rchooseout = src2_r; funSel = FUN_SUB;  end
            OP_AND: begin rchooseout = src2_r; funSel = FUN_AND;  end
            default: begin rchooseout = src1_r; funSel = FUN_PASS; end
          endcase
        end
        ST_M0: begin
          treg       = 1'b1;
          rchooseout = src1_r;
          ldMAR      = 1'b1;
          next_s     = (op_r == OP_ST) ? ST_S1 : ST_M1;
        end
        ST_M2: begin
          tMDR      = 1'b1;
          rchoosein = dst_r;
          reg_write = 1'b1;
          next_s    = ST_F0;
        end
        ST_S1: begin
          treg       = 1'b1;
          rchooseout = src2_r;
          ldMDR      = 1'b1;
          next_s     = ST_S2;
        end
        ST_S2: begin
          mem_wr = 1'b1;
          ldMDB  = 1'b1;
          next_s = mem_ready ? ST_F0 : ST_S2;
        end
        ST_J0: begin
          treg       = 1'b1;
          rchooseout = src1_r;
          ldPC       = 1'b1;
          next_s     = ST_F0;
        end
        ST_HALT: begin
          halted = 1'b1;
          next_s = ST_HALT;
        end
        default: begin
          next_s = ST_F0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed stimulus drives one controller cycle at a time and pushes the
// hand-written expected output vector for that cycle into a scoreboard queue.
// A separate monitor on the falling edge pops and compares against the DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] op_code;
  logic [2:0] dst, src1, src2;
  logic [1:0] addr_mode;
  logic [3:0] flags;
  logic       mem_ready;
  logic ldMDR, ldMDB, ldMAR, ldIR, ldPC, ldR, ldSP, ldYreg;
  logic tMDR, tMAR, tPC, tR, treg, thash4, thash2;
  logic [2:0] rchoosein, rchooseout;
  logic reg_write, reg_read;
  logic [1:0] funSel;
  logic mem_rd, mem_wr, halted, illegal;

  typedef struct packed {
    logic ldMDR, ldMDB, ldMAR, ldIR, ldPC, ldR, ldSP, ldYreg;
    logic tMDR, tMAR, tPC, tR, treg, thash4, thash2;
    logic [2:0] rin;
    logic [2:0] rout;
    logic reg_write, reg_read;
    logic [1:0] fun;
    logic mem_rd, mem_wr, halted, illegal;
  } outs_t;

`ifdef CTRL_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  int    checks = 0;
  int    errors = 0;
  string name_q[$];
  outs_t exp_q[$];

  multicycle_ctrl #(.PC_STEP(2)) dut (
    .clk(clk), .rst(rst), .op_code(op_code), .dst(dst), .src1(src1), .src2(src2),
    .addr_mode(addr_mode), .flags(flags), .mem_ready(mem_ready),
    .ldMDR(ldMDR), .ldMDB(ldMDB), .ldMAR(ldMAR), .ldIR(ldIR), .ldPC(ldPC),
    .ldR(ldR), .ldSP(ldSP), .ldYreg(ldYreg),
    .tMDR(tMDR), .tMAR(tMAR), .tPC(tPC), .tR(tR), .treg(treg),
    .thash4(thash4), .thash2(thash2),
    .rchoosein(rchoosein), .rchooseout(rchooseout),
    .reg_write(reg_write), .reg_read(reg_read), .funSel(funSel),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Expected vectors for each controller cycle, written from the state table.
  function automatic outs_t x_zero();
    outs_t o = '0;
    return o;
  endfunction
  function automatic outs_t x_f0();
    outs_t o = '0;
    o.tPC = 1'b1; o.ldMAR = 1'b1; o.ldYreg = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_f1(input logic rdy);
    outs_t o = '0;
    o.thash2 = 1'b1; o.fun = 2'b01; o.ldPC = 1'b1; o.mem_rd = 1'b1; o.ldMDR = rdy;
    return o;
  endfunction
  function automatic outs_t x_wait(input logic rdy);
    outs_t o = '0;
    o.mem_rd = 1'b1; o.ldMDR = rdy;
    return o;
  endfunction
  function automatic outs_t x_f2();
    outs_t o = '0;
    o.tMDR = 1'b1; o.ldIR = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_dec(input logic ill);
    outs_t o = '0;
    o.illegal = ill;
    return o;
  endfunction
  function automatic outs_t x_e0(input logic [2:0] s);
    outs_t o = '0;
    o.reg_read = 1'b1; o.treg = 1'b1; o.rout = s; o.ldYreg = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_e1(input logic [2:0] s, input logic [2:0] d, input logic [1:0] f);
    outs_t o = '0;
    o.reg_read = 1'b1; o.treg = 1'b1; o.rout = s; o.fun = f; o.rin = d; o.reg_write = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_m0(input logic [2:0] s);
    outs_t o = '0;
    o.treg = 1'b1; o.rout = s; o.ldMAR = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_m2(input logic [2:0] d);
    outs_t o = '0;
    o.tMDR = 1'b1; o.rin = d; o.reg_write = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_s1(input logic [2:0] s);
    outs_t o = '0;
    o.treg = 1'b1; o.rout = s; o.ldMDR = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_s2();
    outs_t o = '0;
    o.mem_wr = 1'b1; o.ldMDB = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_j0(input logic [2:0] s);
    outs_t o = '0;
    o.treg = 1'b1; o.rout = s; o.ldPC = 1'b1;
    return o;
  endfunction
  function automatic outs_t x_halt();
    outs_t o = '0;
    o.halted = 1'b1;
    return o;
  endfunction

  // One controller cycle: drive inputs, queue the expectation, advance.
  task automatic cyc(input string nm, input outs_t e, input logic rdy, input logic rs);
    rst       = rs;
    mem_ready = rdy;
    name_q.push_back(nm);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Zero-wait fetch of one instruction through DEC.
  task automatic fetch(input string p, input logic [4:0] op, input logic [2:0] d,
                       input logic [2:0] s1, input logic [2:0] s2, input logic ill);
    op_code = op; dst = d; src1 = s1; src2 = s2;
    cyc({p, "/F0"},  x_f0(),     1'b1, 1'b1);
    cyc({p, "/F1"},  x_f1(1'b1), 1'b1, 1'b1);
    cyc({p, "/F2"},  x_f2(),     1'b1, 1'b1);
    cyc({p, "/DEC"}, x_dec(ill), 1'b1, 1'b1);
  endtask

  // Monitor: compare every queued expectation against the DUT mid-cycle.
  always @(negedge clk) begin
    outs_t act;
    outs_t e;
    string nm;
    if (exp_q.size() > 0) begin
      act = {ldMDR, ldMDB, ldMAR, ldIR, ldPC, ldR, ldSP, ldYreg,
             tMDR, tMAR, tPC, tR, treg, thash4, thash2,
             rchoosein, rchooseout, reg_write, reg_read, funSel,
             mem_rd, mem_wr, halted, illegal};
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks = checks + 1;
      if (act !== e) begin
        errors = errors + 1;
        $display("FAIL %s: got %h expected %h", nm, act, e);
      end
    end
  end

  initial begin
    rst = 1'b0; mem_ready = 1'b1; op_code = 5'd0; dst = 3'd0; src1 = 3'd0;
    src2 = 3'd0; addr_mode = 2'd0; flags = 4'd0;
    @(posedge clk);
    #1;

    // Reset held three cycles: everything low.
    for (int i = 0; i < 3; i++) cyc("reset", x_zero(), 1'b1, 1'b0);

    // NOP: four cycles then a fresh fetch.
    fetch("nop", 5'b00000, 3'd0, 3'd0, 3'd0, 1'b0);

    // ADD r3 = r1 + r2 with a zero result -> zflag set.
    flags = 4'b1000;
    fetch("add", 5'b00001, 3'd3, 3'd1, 3'd2, 1'b0);
    cyc("add/E0", x_e0(3'd1), 1'b1, 1'b1);
    cyc("add/E1", x_e1(3'd2, 3'd3, 2'b01), 1'b1, 1'b1);
    flags = 4'b0000;

    // BZ r4 taken.
    fetch("bz1", 5'b01001, 3'd0, 3'd4, 3'd0, 1'b0);
    cyc("bz1/J0", x_j0(3'd4), 1'b1, 1'b1);

    // SUB with non-zero result clears zflag.
    fetch("sub", 5'b00010, 3'd5, 3'd6, 3'd7, 1'b0);
    cyc("sub/E0", x_e0(3'd6), 1'b1, 1'b1);
    cyc("sub/E1", x_e1(3'd7, 3'd5, 2'b10), 1'b1, 1'b1);

    // BZ untaken: straight back to F0 (checked by the next fetch).
    fetch("bz0", 5'b01001, 3'd0, 3'd4, 3'd0, 1'b0);

    // AND with zero result sets zflag; MOV with Z low must not clear it.
    flags = 4'b1000;
    fetch("and", 5'b00011, 3'd1, 3'd2, 3'd3, 1'b0);
    cyc("and/E0", x_e0(3'd2), 1'b1, 1'b1);
    cyc("and/E1", x_e1(3'd3, 3'd1, 2'b11), 1'b1, 1'b1);
    flags = 4'b0000;
    fetch("mov", 5'b00100, 3'd2, 3'd6, 3'd0, 1'b0);
    cyc("mov/E0", x_e0(3'd6), 1'b1, 1'b1);
    cyc("mov/E1", x_e1(3'd6, 3'd2, 2'b00), 1'b1, 1'b1);
    fetch("bz2", 5'b01001, 3'd0, 3'd5, 3'd0, 1'b0);
    cyc("bz2/J0", x_j0(3'd5), 1'b1, 1'b1);

    // LD r1 = mem[r2] with three wait cycles in M1 (10 cycles total).
    fetch("ld", 5'b00110, 3'd1, 3'd2, 3'd0, 1'b0);
    cyc("ld/M0", x_m0(3'd2), 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) cyc("ld/M1wait", x_wait(1'b0), 1'b0, 1'b1);
    cyc("ld/M1rdy", x_wait(1'b1), 1'b1, 1'b1);
    cyc("ld/M2", x_m2(3'd1), 1'b1, 1'b1);

    // Fetch with two wait cycles (F1 and one FW not ready).
    op_code = 5'b00000;
    cyc("fw/F0",    x_f0(),       1'b1, 1'b1);
    cyc("fw/F1",    x_f1(1'b0),   1'b0, 1'b1);
    cyc("fw/FW0",   x_wait(1'b0), 1'b0, 1'b1);
    cyc("fw/FWrdy", x_wait(1'b1), 1'b1, 1'b1);
    cyc("fw/F2",    x_f2(),       1'b1, 1'b1);
    cyc("fw/DEC",   x_dec(1'b0),  1'b1, 1'b1);

    // ST mem[r1] = r2 with two wait cycles in S2.
    fetch("st", 5'b00111, 3'd0, 3'd1, 3'd2, 1'b0);
    cyc("st/M0", x_m0(3'd1), 1'b1, 1'b1);
    cyc("st/S1", x_s1(3'd2), 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) cyc("st/S2wait", x_s2(), 1'b0, 1'b1);
    cyc("st/S2rdy", x_s2(), 1'b1, 1'b1);

    // LDI r4 with one wait on the immediate read.
    fetch("ldi", 5'b00101, 3'd4, 3'd0, 3'd0, 1'b0);
    cyc("ldi/I0",    x_f0(),       1'b1, 1'b1);
    cyc("ldi/I1",    x_f1(1'b0),   1'b0, 1'b1);
    cyc("ldi/IWrdy", x_wait(1'b1), 1'b1, 1'b1);
    cyc("ldi/M2",    x_m2(3'd4),   1'b1, 1'b1);

    // JMP r5.
    fetch("jmp", 5'b01000, 3'd0, 3'd5, 3'd0, 1'b0);
    cyc("jmp/J0", x_j0(3'd5), 1'b1, 1'b1);

    // Reset during a fetch wait: request drops at once, restart at F0.
    op_code = 5'b00000;
    cyc("rw/F0",  x_f0(),       1'b1, 1'b1);
    cyc("rw/F1",  x_f1(1'b0),   1'b0, 1'b1);
    cyc("rw/FW",  x_wait(1'b0), 1'b0, 1'b1);
    cyc("rw/rst", x_zero(),     1'b0, 1'b0);
    fetch("rw/after", 5'b00000, 3'd0, 3'd0, 3'd0, 1'b0);

    // HALT is absorbing; only reset leaves it.
    fetch("halt", 5'b11111, 3'd0, 3'd0, 3'd0, 1'b0);
    for (int i = 0; i < 3; i++) cyc("halt/HALT", x_halt(), 1'b1, 1'b1);
    cyc("halt/rst", x_zero(), 1'b1, 1'b0);

    // Undefined opcode 10101: trap to HALT, or behave as NOP.
    fetch("ill", 5'b10101, 3'd0, 3'd0, 3'd0, TRAP);
`ifdef CTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++) cyc("ill/HALT", x_halt(), 1'b1, 1'b1);
`else
    fetch("ill/next", 5'b00000, 3'd0, 3'd0, 3'd0, 1'b0);
`endif

    // Let the monitor consume the last expectation.
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
